// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access path: access-type codes,
// FSM state encoding and store-side lane helpers.
package dmem_pkg;

  localparam logic [2:0] DM_W  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_HU = 3'b010;
  localparam logic [2:0] DM_B  = 3'b011;
  localparam logic [2:0] DM_BU = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_TRAP
  } state_t;

  typedef enum logic [1:0] {
    SZ_W,
    SZ_H,
    SZ_B
  } size_t;

  // Unknown type codes fall back to word accesses.
  function automatic size_t access_size(input logic [2:0] t);
    case (t)
      DM_H, DM_HU: return SZ_H;
      DM_B, DM_BU: return SZ_B;
      default:     return SZ_W;
    endcase
  endfunction

  function automatic logic is_signed_type(input logic [2:0] t);
    return (t == DM_H) || (t == DM_B);
  endfunction

  function automatic logic misaligned(input logic [2:0] t, input logic [1:0] off);
    case (access_size(t))
      SZ_H:    return off[0];
      SZ_B:    return 1'b0;
      default: return off != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(input logic [2:0] t, input logic [1:0] off);
    case (access_size(t))
      SZ_H:    return off[1] ? 4'b1100 : 4'b0011;
      SZ_B:    return 4'b0001 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_align(input logic [2:0] t, input logic [31:0] wdata);
    case (access_size(t))
      SZ_H:    return {2{wdata[15:0]}};
      SZ_B:    return {4{wdata[7:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/dmem_access_unit_if.sv
// Request/response handshake plus RAM port of the MEM-stage access unit.
interface dmem_access_unit_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned TYPE_W = 3
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic [TYPE_W-1:0] req_type;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_misalign;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  // The access unit side.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_type, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_misalign, busy,
           mem_addr, mem_we, mem_wdata
  );

  // Pipeline and RAM side.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_type, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_misalign, busy,
           mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/dmem_access_unit_load_formatter.sv
// Selects the addressed byte/half of a RAM word and sign- or zero-extends it.
module load_formatter
  import dmem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  acc_type,
  input  logic [1:0]  off,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sgn;

  always_comb begin
    byte_sel = rdata[7:0];
    case (off)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    sgn      = is_signed_type(acc_type);
    case (access_size(acc_type))
      SZ_B:    result = {{24{sgn & byte_sel[7]}}, byte_sel};
      SZ_H:    result = {{16{sgn & half_sel[15]}}, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory initiator: one request at a time, registered RAM
// strobes, load formatting after the RAM's one-cycle read latency.
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned TYPE_W = 3
) (
  input logic          clk,
  input logic          rst,
  dmem_access_unit_if.slave bus
);

  state_t            state, next_state;
  logic              we_q;
  logic [TYPE_W-1:0] type_q;
  logic [1:0]        off_q;
  logic              accept;
  logic              mis;
  logic [31:0]       load_result;
  logic              unused;

  assign unused = ^{bus.req_addr[31:ADDR_W+2]};

  assign accept = bus.req_valid & bus.req_ready;
  assign mis    = misaligned(bus.req_type, bus.req_addr[1:0]);
  assign bus.busy = (state != S_IDLE) | (bus.req_valid & ~bus.req_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Stores also pass through WAIT so every memory access answers at T+3.
  always_comb begin
    next_state    = state;
    bus.req_ready = 1'b0;
    case (state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (accept) next_state = mis ? S_TRAP : S_ISSUE;
      end
      S_ISSUE: next_state = S_WAIT;
      S_WAIT:  next_state = S_RESP;
      S_RESP:  next_state = S_IDLE;
      S_TRAP:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  load_formatter u_fmt (
    .rdata    (bus.mem_rdata),
    .acc_type (type_q),
    .off      (off_q),
    .result   (load_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q              <= 1'b0;
      type_q            <= '0;
      off_q             <= '0;
      bus.mem_addr      <= '0;
      bus.mem_we        <= '0;
      bus.mem_wdata     <= '0;
      bus.resp_valid    <= 1'b0;
      bus.resp_rdata    <= '0;
      bus.resp_misalign <= 1'b0;
    end else begin
      bus.mem_we        <= '0;
      bus.resp_valid    <= 1'b0;
      bus.resp_misalign <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            we_q           <= bus.req_we;
            type_q         <= bus.req_type;
            off_q          <= bus.req_addr[1:0];
            bus.resp_rdata <= '0;
            if (mis) begin
              bus.resp_valid    <= 1'b1;
              bus.resp_misalign <= 1'b1;
            end else begin
              bus.mem_addr <= bus.req_addr[ADDR_W+1:2];
              if (bus.req_we) begin
                bus.mem_we    <= byte_enable(bus.req_type, bus.req_addr[1:0]);
                bus.mem_wdata <= lane_align(bus.req_type, bus.req_wdata);
              end
            end
          end
        end
        S_WAIT: begin
          bus.resp_rdata <= we_q ? '0 : load_result;
          bus.resp_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: stores, formatted loads, traps,
// back-to-back requests and asynchronous reset mid-operation.
module tb_dmem_access_unit;
  import dmem_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  dmem_access_unit_if #(.ADDR_W(10), .TYPE_W(3)) bus ();

  dmem_access_unit #(.ADDR_W(10), .TYPE_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one aligned request and checks it through T+4.
  task automatic run_access(input string tag, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [2:0] typ,
                            input logic [31:0] ram_word, input logic [9:0] exp_addr,
                            input logic [3:0] exp_we, input logic [31:0] exp_wdata,
                            input logic [31:0] exp_rdata);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_type  = typ;
    bus.mem_rdata = ram_word;
    tick();
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'hFFFF_FFFF;
    bus.req_wdata = 32'h0;
    chk({tag, " T1 mem_addr"}, {22'd0, bus.mem_addr}, {22'd0, exp_addr});
    chk({tag, " T1 mem_we"}, {28'd0, bus.mem_we}, {28'd0, exp_we});
    if (we) chk({tag, " T1 mem_wdata"}, bus.mem_wdata, exp_wdata);
    chk({tag, " T1 busy"}, {31'd0, bus.busy}, 32'd1);
    chk({tag, " T1 req_ready"}, {31'd0, bus.req_ready}, 32'd0);
    chk({tag, " T1 resp_valid"}, {31'd0, bus.resp_valid}, 32'd0);
    tick();
    chk({tag, " T2 mem_we"}, {28'd0, bus.mem_we}, 32'd0);
    chk({tag, " T2 resp_valid"}, {31'd0, bus.resp_valid}, 32'd0);
    tick();
    chk({tag, " T3 resp_valid"}, {31'd0, bus.resp_valid}, 32'd1);
    chk({tag, " T3 resp_misalign"}, {31'd0, bus.resp_misalign}, 32'd0);
    chk({tag, " T3 resp_rdata"}, bus.resp_rdata, exp_rdata);
    tick();
    chk({tag, " T4 resp_valid"}, {31'd0, bus.resp_valid}, 32'd0);
    chk({tag, " T4 req_ready"}, {31'd0, bus.req_ready}, 32'd1);
  endtask

  initial begin
    int we_cycles;
    int resp_cycles;
    int idle_cycles;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_type  = DM_W;
    bus.mem_rdata = '0;
    tick();
    tick();
    chk("reset req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("reset resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("reset resp_rdata", bus.resp_rdata, 32'd0);
    chk("reset resp_misalign", {31'd0, bus.resp_misalign}, 32'd0);
    chk("reset mem_we", {28'd0, bus.mem_we}, 32'd0);
    chk("reset mem_addr", {22'd0, bus.mem_addr}, 32'd0);
    chk("reset mem_wdata", bus.mem_wdata, 32'd0);
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    rst = 1'b0;
    tick();

    run_access("SW 100", 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, DM_W, 32'h0, 10'h040, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    run_access("SB 103", 1'b1, 32'h0000_0103, 32'h0000_00A5, DM_B, 32'h0, 10'h040, 4'b1000, 32'hA5A5_A5A5, 32'h0);
    run_access("SB 101", 1'b1, 32'h0000_0101, 32'h1234_563C, DM_B, 32'h0, 10'h040, 4'b0010, 32'h3C3C_3C3C, 32'h0);
    run_access("SH 102", 1'b1, 32'h0000_0102, 32'h0000_BEEF, DM_H, 32'h0, 10'h040, 4'b1100, 32'hBEEF_BEEF, 32'h0);
    run_access("SHU 100", 1'b1, 32'h0000_0100, 32'h7777_1234, DM_HU, 32'h0, 10'h040, 4'b0011, 32'h1234_1234, 32'h0);
    run_access("S type7", 1'b1, 32'h0000_0010, 32'h0102_0304, 3'b111, 32'h0, 10'h004, 4'b1111, 32'h0102_0304, 32'h0);
    run_access("LB 103", 1'b0, 32'h0000_0103, 32'h0, DM_B, 32'hA512_3456, 10'h040, 4'b0000, 32'h0, 32'hFFFF_FFA5);
    run_access("LBU 103", 1'b0, 32'h0000_0103, 32'h0, DM_BU, 32'hA512_3456, 10'h040, 4'b0000, 32'h0, 32'h0000_00A5);
    run_access("LB 101", 1'b0, 32'h0000_0101, 32'h0, DM_B, 32'h1122_7F44, 10'h040, 4'b0000, 32'h0, 32'h0000_007F);
    run_access("LH 202", 1'b0, 32'h0000_0202, 32'h0, DM_H, 32'h8001_7FFF, 10'h080, 4'b0000, 32'h0, 32'hFFFF_8001);
    run_access("LHU 200", 1'b0, 32'h0000_0200, 32'h0, DM_HU, 32'h8001_7FFF, 10'h080, 4'b0000, 32'h0, 32'h0000_7FFF);
    run_access("LHU 202", 1'b0, 32'h0000_0202, 32'h0, DM_HU, 32'h8001_7FFF, 10'h080, 4'b0000, 32'h0, 32'h0000_8001);
    run_access("LW wrap", 1'b0, 32'hFFFF_F104, 32'h0, DM_W, 32'hCAFE_F00D, 10'h041, 4'b0000, 32'h0, 32'hCAFE_F00D);

    // Misaligned word load traps; a new request waits only one cycle.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h0000_0006;
    bus.req_type  = DM_W;
    tick();
    chk("trap resp_valid", {31'd0, bus.resp_valid}, 32'd1);
    chk("trap resp_misalign", {31'd0, bus.resp_misalign}, 32'd1);
    chk("trap resp_rdata", bus.resp_rdata, 32'd0);
    chk("trap mem_we", {28'd0, bus.mem_we}, 32'd0);
    chk("trap req_ready", {31'd0, bus.req_ready}, 32'd0);
    bus.req_addr  = 32'h0000_0008;
    bus.mem_rdata = 32'h1234_5678;
    tick();
    chk("post-trap req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("post-trap resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("post-trap misalign", {31'd0, bus.resp_misalign}, 32'd0);
    tick();
    bus.req_valid = 1'b0;
    chk("post-trap mem_addr", {22'd0, bus.mem_addr}, 32'h002);
    chk("post-trap busy", {31'd0, bus.busy}, 32'd1);
    tick();
    tick();
    chk("post-trap load valid", {31'd0, bus.resp_valid}, 32'd1);
    chk("post-trap load rdata", bus.resp_rdata, 32'h1234_5678);
    tick();

    // Misaligned half store: no write strobe at all.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h0000_0101;
    bus.req_wdata = 32'hFFFF_FFFF;
    bus.req_type  = DM_H;
    tick();
    bus.req_valid = 1'b0;
    chk("SH trap misalign", {31'd0, bus.resp_misalign}, 32'd1);
    chk("SH trap mem_we", {28'd0, bus.mem_we}, 32'd0);
    tick();
    chk("SH trap after valid", {31'd0, bus.resp_valid}, 32'd0);

    // Three back-to-back stores with req_valid held high.
    we_cycles = 0;
    resp_cycles = 0;
    idle_cycles = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h0000_0010;
    bus.req_wdata = 32'h5555_AAAA;
    bus.req_type  = DM_W;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.mem_we != 4'b0000) begin
        we_cycles++;
        chk("b2b ready in ISSUE", {31'd0, bus.req_ready}, 32'd0);
        chk("b2b busy in ISSUE", {31'd0, bus.busy}, 32'd1);
      end
      if (bus.resp_valid) begin
        resp_cycles++;
        chk("b2b ready in RESP", {31'd0, bus.req_ready}, 32'd0);
      end
      if (bus.req_ready) idle_cycles++;
    end
    bus.req_valid = 1'b0;
    chk("b2b we pulses", we_cycles, 32'd3);
    chk("b2b resp pulses", resp_cycles, 32'd3);
    chk("b2b idle cycles", idle_cycles, 32'd3);
    tick();
    tick();
    tick();
    tick();

    // Reset during the ISSUE cycle of a store drops the strobe at once.
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_0020;
    tick();
    bus.req_valid = 1'b0;
    chk("rst-issue mem_we before", {28'd0, bus.mem_we}, 32'h0000_000F);
    #2 rst = 1'b1;
    #1;
    chk("rst-issue mem_we async", {28'd0, bus.mem_we}, 32'd0);
    chk("rst-issue mem_addr async", {22'd0, bus.mem_addr}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Reset during WAIT of a load: no response ever appears.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h0000_0030;
    bus.req_type  = DM_W;
    bus.mem_rdata = 32'h8765_4321;
    tick();
    bus.req_valid = 1'b0;
    tick();
    chk("rst-wait busy before", {31'd0, bus.busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst-wait resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst-wait req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst-wait busy", {31'd0, bus.busy}, 32'd0);
    chk("rst-wait mem_addr", {22'd0, bus.mem_addr}, 32'd0);
    chk("rst-wait resp_rdata", bus.resp_rdata, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    resp_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.resp_valid) resp_cycles++;
    end
    chk("rst-wait no response", resp_cycles, 32'd0);
    chk("rst-wait ready after", {31'd0, bus.req_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
